// File: rtl/gfg_scene_pkg.sv
// Shared definitions for the triangle scene sequencer.
//   - state_e      : sequencer FSM state encoding
//   - tri_entry_t  : scene ROM entry layout {valid, p0x, p0y, p1x, p1y, p2x, p2y, color}
//   - scene_entry(): constant scene table, addressed by {scene, tri_idx}
// Coordinates are stored at a fixed 8-bit width and narrowed to the raster width by the user.
package gfg_scene_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFetch    = 3'd1,
        StGo       = 3'd2,
        StWaitAck  = 3'd3,
        StWaitDone = 3'd4,
        StNext     = 3'd5,
        StUpdate   = 3'd6
    } state_e;

    localparam int unsigned RomCoordW  = 8;
    localparam int unsigned RomColorW  = 12;
    // Cycles spent waiting for the rasterizer to drop done before assuming an instant finish.
    localparam int unsigned AckTimeout = 4;

    typedef struct packed {
        logic                 valid;
        logic [RomCoordW-1:0] p0x;
        logic [RomCoordW-1:0] p0y;
        logic [RomCoordW-1:0] p1x;
        logic [RomCoordW-1:0] p1y;
        logic [RomCoordW-1:0] p2x;
        logic [RomCoordW-1:0] p2y;
        logic [RomColorW-1:0] color;
    } tri_entry_t;

    localparam int unsigned EntryW = $bits(tri_entry_t);

    function automatic tri_entry_t make_tri(input int unsigned x0, input int unsigned y0,
                                            input int unsigned x1, input int unsigned y1,
                                            input int unsigned x2, input int unsigned y2,
                                            input logic [RomColorW-1:0] color);
        tri_entry_t e;
        e.valid = 1'b1;
        e.p0x   = RomCoordW'(x0);
        e.p0y   = RomCoordW'(y0);
        e.p1x   = RomCoordW'(x1);
        e.p1y   = RomCoordW'(y1);
        e.p2x   = RomCoordW'(x2);
        e.p2y   = RomCoordW'(y2);
        e.color = color;
        return e;
    endfunction

    // Every base vertex leaves room for the largest bounce offset (x <= 63, y <= 51 at 80x60).
    function automatic tri_entry_t scene_entry(input logic [1:0] scene, input logic [2:0] idx);
        tri_entry_t e;
        e = '0;
        case ({scene, idx})
            5'b00_000: e = make_tri(10, 10, 10, 40, 50, 25, 12'hF00);
            5'b01_000: e = make_tri(40,  5,  5, 50, 60, 50, 12'h0F0);
            5'b01_001: e = make_tri(20, 20, 30, 20, 25, 30, 12'h00F);
            5'b11_000: e = make_tri( 5,  5, 20,  5, 12, 15, 12'hFF0);
            5'b11_001: e = make_tri(30, 10, 45, 10, 38, 25, 12'h0FF);
            5'b11_010: e = make_tri(50, 30, 62, 30, 56, 45, 12'hF0F);
            5'b11_011: e = make_tri( 8, 35, 25, 50,  3, 51, 12'hFFF);
            default:   e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/scene_rom.sv
// Synchronous-read scene ROM; contents come from gfg_scene_pkg::scene_entry.
//   i_clk   : clock
//   scene_i : scene index (upper address bits)
//   idx_i   : triangle index within the scene (lower address bits)
//   data_o  : packed tri_entry_t, valid the cycle after the address is presented
module scene_rom
    import gfg_scene_pkg::*;
#(
    parameter int unsigned IdxW = 2
) (
    input  logic              i_clk,
    input  logic [1:0]        scene_i,
    input  logic [IdxW-1:0]   idx_i,
    output logic [EntryW-1:0] data_o
);

    logic [2:0] idx_ext;

    always_comb begin
        idx_ext = 3'(idx_i);
    end

    always_ff @(posedge i_clk) begin
        data_o <= scene_entry(scene_i, idx_ext);
    end

endmodule

// File: rtl/triangle_scene_sequencer.sv
// Per-frame triangle source for the rasterizer. On each new-frame pulse it walks the selected
// scene's triangle list and issues one go/done job per valid triangle, each vertex being the
// ROM base plus a bouncing (x,y) offset that steps once per completed frame.
//   i_clk, srst_n    : clock, synchronous active-low reset
//   i_new_frame      : frame-start pulse
//   i_raster_done    : rasterizer idle level
//   i_scene_sel      : scene index, sampled at frame start
//   i_pause          : freezes the bounce offsets
//   o_go             : rasterizer start pulse
//   o_p*_x, o_p*_y   : vertex coordinates
//   o_color          : fill colour
//   o_busy           : sequencer not idle
//   o_frame_done     : pulse once the frame's triangle list is exhausted
//   o_overrun        : pulse when a frame start arrives while busy
module triangle_scene_sequencer
    import gfg_scene_pkg::*;
#(
    parameter int unsigned HORIZ_RESOLUTION = 80,
    parameter int unsigned VERT_RESOLUTION  = 60,
    parameter int unsigned MAX_TRIS         = 4,
    parameter int unsigned MAX_OFFSET_X     = 16,
    parameter int unsigned MAX_OFFSET_Y     = 8,
    parameter int unsigned COLOR_DEPTH      = 12,
    localparam int unsigned XW = $clog2(HORIZ_RESOLUTION),
    localparam int unsigned YW = $clog2(VERT_RESOLUTION),
    localparam int unsigned IW = (MAX_TRIS > 1) ? $clog2(MAX_TRIS) : 1
) (
    input  logic                   i_clk,
    input  logic                   srst_n,
    input  logic                   i_new_frame,
    input  logic                   i_raster_done,
    input  logic [1:0]             i_scene_sel,
    input  logic                   i_pause,
    output logic                   o_go,
    output logic [XW-1:0]          o_p0_x,
    output logic [XW-1:0]          o_p1_x,
    output logic [XW-1:0]          o_p2_x,
    output logic [YW-1:0]          o_p0_y,
    output logic [YW-1:0]          o_p1_y,
    output logic [YW-1:0]          o_p2_y,
    output logic [COLOR_DEPTH-1:0] o_color,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_overrun
);

    localparam logic [XW-1:0] MaxOffX = XW'(MAX_OFFSET_X);
    localparam logic [YW-1:0] MaxOffY = YW'(MAX_OFFSET_Y);
    localparam logic [XW-1:0] OneX    = XW'(1);
    localparam logic [YW-1:0] OneY    = YW'(1);
    localparam logic [IW-1:0] LastIdx = IW'(MAX_TRIS - 1);
    localparam logic [IW-1:0] OneIdx  = IW'(1);
    localparam logic [1:0]    AckLast = 2'(AckTimeout - 1);

    state_e          state_q;
    logic [1:0]      scene_q;
    logic [IW-1:0]   tri_idx_q;
    logic [1:0]      ack_cnt_q;
    logic [XW-1:0]   off_x_q;
    logic [YW-1:0]   off_y_q;
    logic            vel_x_neg_q;
    logic            vel_y_neg_q;

    logic [XW-1:0]   off_x_nxt;
    logic [YW-1:0]   off_y_nxt;
    logic            vel_x_neg_nxt;
    logic            vel_y_neg_nxt;

    logic [EntryW-1:0] rom_data;
    tri_entry_t        entry;
    logic              show;

    // Address is held constant from FETCH until NEXT, so the ROM output register keeps
    // presenting the same entry for the whole job.
    scene_rom #(
        .IdxW (IW)
    ) u_scene_rom (
        .i_clk   (i_clk),
        .scene_i (scene_q),
        .idx_i   (tri_idx_q),
        .data_o  (rom_data)
    );

    always_comb begin
        entry = rom_data;
    end

    // Bounce step: reflect at the limits so the offset traces a triangle wave 0..MAX..0.
    always_comb begin
        off_x_nxt     = off_x_q;
        vel_x_neg_nxt = vel_x_neg_q;
        if (!vel_x_neg_q && off_x_q == MaxOffX) begin
            vel_x_neg_nxt = 1'b1;
            off_x_nxt     = MaxOffX - OneX;
        end else if (vel_x_neg_q && off_x_q == '0) begin
            vel_x_neg_nxt = 1'b0;
            off_x_nxt     = OneX;
        end else if (vel_x_neg_q) begin
            off_x_nxt     = off_x_q - OneX;
        end else begin
            off_x_nxt     = off_x_q + OneX;
        end

        off_y_nxt     = off_y_q;
        vel_y_neg_nxt = vel_y_neg_q;
        if (!vel_y_neg_q && off_y_q == MaxOffY) begin
            vel_y_neg_nxt = 1'b1;
            off_y_nxt     = MaxOffY - OneY;
        end else if (vel_y_neg_q && off_y_q == '0) begin
            vel_y_neg_nxt = 1'b0;
            off_y_nxt     = OneY;
        end else if (vel_y_neg_q) begin
            off_y_nxt     = off_y_q - OneY;
        end else begin
            off_y_nxt     = off_y_q + OneY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!srst_n) begin
            state_q     <= StIdle;
            scene_q     <= '0;
            tri_idx_q   <= '0;
            ack_cnt_q   <= '0;
            off_x_q     <= '0;
            off_y_q     <= '0;
            vel_x_neg_q <= 1'b0;
            vel_y_neg_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_new_frame) begin
                        scene_q   <= i_scene_sel;
                        tri_idx_q <= '0;
                        state_q   <= StFetch;
                    end
                end
                StFetch: begin
                    state_q <= StGo;
                end
                StGo: begin
                    if (!entry.valid) begin
                        state_q <= StUpdate;
                    end else if (i_raster_done) begin
                        ack_cnt_q <= '0;
                        state_q   <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (!i_raster_done) begin
                        state_q <= StWaitDone;
                    end else if (ack_cnt_q == AckLast) begin
                        // Rasterizer never dropped done: treat the job as already finished.
                        state_q <= StNext;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 2'd1;
                    end
                end
                StWaitDone: begin
                    if (i_raster_done) begin
                        state_q <= StNext;
                    end
                end
                StNext: begin
                    if (tri_idx_q == LastIdx) begin
                        state_q <= StUpdate;
                    end else begin
                        tri_idx_q <= tri_idx_q + OneIdx;
                        state_q   <= StFetch;
                    end
                end
                StUpdate: begin
                    if (!i_pause) begin
                        off_x_q     <= off_x_nxt;
                        off_y_q     <= off_y_nxt;
                        vel_x_neg_q <= vel_x_neg_nxt;
                        vel_y_neg_q <= vel_y_neg_nxt;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Vertex outputs are sums of registers (ROM output and offsets) that stay fixed from GO
    // through WAIT_DONE, so they are valid in the o_go cycle and stable for the whole job.
    always_comb begin
        show = ((state_q == StGo) && entry.valid) || (state_q == StWaitAck) ||
               (state_q == StWaitDone);

        o_p0_x  = '0;
        o_p1_x  = '0;
        o_p2_x  = '0;
        o_p0_y  = '0;
        o_p1_y  = '0;
        o_p2_y  = '0;
        o_color = '0;
        if (show) begin
            o_p0_x  = XW'(entry.p0x) + off_x_q;
            o_p1_x  = XW'(entry.p1x) + off_x_q;
            o_p2_x  = XW'(entry.p2x) + off_x_q;
            o_p0_y  = YW'(entry.p0y) + off_y_q;
            o_p1_y  = YW'(entry.p1y) + off_y_q;
            o_p2_y  = YW'(entry.p2y) + off_y_q;
            o_color = COLOR_DEPTH'(entry.color);
        end

        o_go         = (state_q == StGo) && entry.valid && i_raster_done;
        o_busy       = (state_q != StIdle);
        o_frame_done = (state_q == StUpdate);
        o_overrun    = i_new_frame && (state_q != StIdle);
    end

endmodule

// File: tb/tb_triangle_scene_sequencer.sv
module tb_triangle_scene_sequencer;

    localparam int HR  = 80;
    localparam int VR  = 60;
    localparam int MT  = 4;
    localparam int MOX = 16;
    localparam int MOY = 8;
    localparam int CD  = 12;
    localparam int XW  = $clog2(HR);
    localparam int YW  = $clog2(VR);

    logic          clk = 1'b0;
    logic          srst_n = 1'b0;
    logic          new_frame = 1'b0;
    logic          raster_done = 1'b1;
    logic [1:0]    scene_sel = 2'd0;
    logic          pause = 1'b0;
    logic          o_go;
    logic [XW-1:0] o_p0_x, o_p1_x, o_p2_x;
    logic [YW-1:0] o_p0_y, o_p1_y, o_p2_y;
    logic [CD-1:0] o_color;
    logic          o_busy, o_frame_done, o_overrun;

    always #5 clk = ~clk;

    triangle_scene_sequencer #(
        .HORIZ_RESOLUTION (HR),
        .VERT_RESOLUTION  (VR),
        .MAX_TRIS         (MT),
        .MAX_OFFSET_X     (MOX),
        .MAX_OFFSET_Y     (MOY),
        .COLOR_DEPTH      (CD)
    ) dut (
        .i_clk         (clk),
        .srst_n        (srst_n),
        .i_new_frame   (new_frame),
        .i_raster_done (raster_done),
        .i_scene_sel   (scene_sel),
        .i_pause       (pause),
        .o_go          (o_go),
        .o_p0_x        (o_p0_x),
        .o_p1_x        (o_p1_x),
        .o_p2_x        (o_p2_x),
        .o_p0_y        (o_p0_y),
        .o_p1_y        (o_p1_y),
        .o_p2_y        (o_p2_y),
        .o_color       (o_color),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_overrun     (o_overrun)
    );

    // Reference scene table: p0x,p0y,p1x,p1y,p2x,p2y,color
    int tab [4][4][7];
    bit tvalid [4][4];

    int n_assert = 0;
    int n_fail   = 0;
    int n_upd    = 0;   // completed unpaused frames since reset

    // Monitor / rasterizer model state
    int cyc = 0;
    int low_left = 0;
    bit job_live = 0;
    bit stuck = 0;
    int live_v [7];
    int stab_err = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;
    int ov_cnt = 0;
    int go_flat [$];
    int go_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int cur [7];
        cur = '{int'(o_p0_x), int'(o_p0_y), int'(o_p1_x), int'(o_p1_y),
                int'(o_p2_x), int'(o_p2_y), int'(o_color)};
        if (job_live && srst_n && !raster_done) begin
            for (int k = 0; k < 7; k++) if (cur[k] != live_v[k]) stab_err++;
        end
        if (!srst_n) job_live = 0;
        if (o_frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (o_overrun) ov_cnt++;
        if (o_go && srst_n) begin
            for (int k = 0; k < 7; k++) go_flat.push_back(cur[k]);
            go_cyc.push_back(cyc);
            live_v   = cur;
            job_live = 1;
            if (!stuck) low_left = 21;
        end else if (low_left > 0) begin
            low_left--;
            raster_done = (low_left == 0);
            if (low_left == 0) job_live = 0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_tri(input int s, input int i, input int a, input int b, input int c,
                           input int d, input int e, input int f, input int col);
        tab[s][i] = '{a, b, c, d, e, f, col};
        tvalid[s][i] = 1'b1;
    endtask

    function automatic int tri_wave(input int n, input int m);
        int p;
        p = n % (2 * m);
        return (p <= m) ? p : 2 * m - p;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_go"}, int'(o_go), 0);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_fdone"}, int'(o_frame_done), 0);
        check({tag, "_overrun"}, int'(o_overrun), 0);
        check({tag, "_coords"},
              int'(|{o_p0_x, o_p0_y, o_p1_x, o_p1_y, o_p2_x, o_p2_y, o_color}), 0);
    endtask

    // One frame: pulse new_frame, optionally inject a second pulse (and a scene change) k
    // cycles later, wait for frame_done, then compare the issued jobs against the table.
    task automatic run_frame(input int s, input int inject, input bit chk_lat);
        int fd0, ng0, ov0, nf, exp_n, got, j, offx, offy, v;
        bit seen;
        fd0 = fd_cnt;
        ng0 = go_cyc.size();
        ov0 = ov_cnt;
        @(posedge clk); #1;
        new_frame = 1'b1;
        scene_sel = 2'(s);
        nf = cyc;
        seen = 0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (fd_cnt > fd0) begin
                seen = 1;
                break;
            end
            new_frame = (k == inject);
            if (k == inject) scene_sel = 2'(s + 1);
        end
        new_frame = 1'b0;
        check("frame_done_seen", int'(seen), 1);
        check("frame_done_count", fd_cnt - fd0, 1);

        exp_n = 0;
        for (int i = 0; i < MT; i++) if (tvalid[s][i]) exp_n++;
        got = go_cyc.size() - ng0;
        check($sformatf("go_count_s%0d", s), got, exp_n);

        offx = tri_wave(n_upd, MOX);
        offy = tri_wave(n_upd, MOY);
        j = 0;
        for (int i = 0; i < MT; i++) begin
            if (tvalid[s][i] && j < got) begin
                for (int k = 0; k < 7; k++) begin
                    v = tab[s][i][k] + ((k == 6) ? 0 : ((k % 2 == 0) ? offx : offy));
                    check($sformatf("s%0d_t%0d_f%0d_n%0d", s, i, k, n_upd),
                          go_flat[(ng0 + j) * 7 + k], v);
                end
                check("coords_in_raster",
                      int'(go_flat[(ng0 + j) * 7 + 0] <= HR - 1 &&
                           go_flat[(ng0 + j) * 7 + 2] <= HR - 1 &&
                           go_flat[(ng0 + j) * 7 + 4] <= HR - 1 &&
                           go_flat[(ng0 + j) * 7 + 1] <= VR - 1 &&
                           go_flat[(ng0 + j) * 7 + 3] <= VR - 1 &&
                           go_flat[(ng0 + j) * 7 + 5] <= VR - 1), 1);
                j++;
            end
        end
        if (chk_lat && got > 0) check("go_latency", go_cyc[ng0] - nf, 2);
        if (exp_n == 0) check("empty_fd_latency", fd_cyc - nf, 3);
        if (inject > 0) check("overrun_pulses", ov_cnt - ov0, 1);
        else check("no_overrun", ov_cnt - ov0, 0);
        if (!pause) n_upd++;
    endtask

    initial begin
        int fd0, ng0;
        bit ok;

        set_tri(0, 0, 10, 10, 10, 40, 50, 25, 'hF00);
        set_tri(1, 0, 40,  5,  5, 50, 60, 50, 'h0F0);
        set_tri(1, 1, 20, 20, 30, 20, 25, 30, 'h00F);
        set_tri(3, 0,  5,  5, 20,  5, 12, 15, 'hFF0);
        set_tri(3, 1, 30, 10, 45, 10, 38, 25, 'h0FF);
        set_tri(3, 2, 50, 30, 62, 30, 56, 45, 'hF0F);
        set_tri(3, 3,  8, 35, 25, 50,  3, 51, 'hFFF);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        srst_n = 1'b1;
        repeat (2) @(posedge clk);

        // First frame with latency check, then scene 1 at offset (1,1)
        run_frame(0, 0, 1);
        run_frame(1, 0, 1);

        // Long run on scene 0 through both bounce points
        for (int f = 0; f < 17; f++) run_frame(0, 0, 0);

        // Empty scene
        run_frame(2, 0, 0);

        // Overrun during WAIT_DONE plus an ignored mid-frame scene change
        run_frame(1, 8, 0);

        // Paused frames keep the offsets
        pause = 1'b1;
        for (int f = 0; f < 3; f++) run_frame(0, 0, 0);
        pause = 1'b0;

        run_frame(3, 0, 0);

        // Random scenes and pause
        for (int f = 0; f < 8; f++) begin
            pause = 1'($urandom_range(0, 1));
            run_frame(int'($urandom_range(0, 3)), 0, 0);
        end
        pause = 1'b0;
        run_frame(1, 0, 0);

        // Reset in the middle of a job
        ng0 = go_cyc.size();
        @(posedge clk); #1;
        new_frame = 1'b1;
        scene_sel = 2'd0;
        @(posedge clk); #1;
        new_frame = 1'b0;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (go_cyc.size() > ng0) begin
                ok = 1;
                break;
            end
        end
        check("midreset_go_seen", int'(ok), 1);
        repeat (6) @(posedge clk);
        #1;
        check("midreset_busy_before", int'(o_busy), 1);
        fd0 = fd_cnt;
        srst_n = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("midreset");
        srst_n = 1'b1;
        n_upd = 0;
        repeat (10) @(posedge clk);
        #1;
        check("midreset_no_fdone", fd_cnt - fd0, 0);
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (raster_done) begin
                ok = 1;
                break;
            end
        end
        check("raster_idle_again", int'(ok), 1);
        run_frame(0, 0, 1);

        // Rasterizer that never drops done: job assumed complete after the ack timeout
        stuck = 1'b1;
        run_frame(0, 0, 1);
        check("stuck_fd_after_go", fd_cyc - go_cyc[go_cyc.size() - 1], 8);
        run_frame(1, 0, 1);

        check("coord_stability_errors", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
